// File: rtl/mem_lsu_pkg.sv
// Shared types, op codes and helper functions for the handshaked load/store unit.
// Optional feature macro: MEM_LSU_ALIGN_EXC_EN (misaligned halfword/word ops raise
// a misalignment response instead of touching the bus).
package mem_lsu_pkg;

  localparam int REG_W   = 32;
  localparam int ALUOP_W = 8;

  // Load/store op codes presented by EX on ex_aluop.
  localparam logic [ALUOP_W-1:0] OP_LB  = 8'hE0;
  localparam logic [ALUOP_W-1:0] OP_LH  = 8'hE1;
  localparam logic [ALUOP_W-1:0] OP_LWL = 8'hE2;
  localparam logic [ALUOP_W-1:0] OP_LW  = 8'hE3;
  localparam logic [ALUOP_W-1:0] OP_LBU = 8'hE4;
  localparam logic [ALUOP_W-1:0] OP_LHU = 8'hE5;
  localparam logic [ALUOP_W-1:0] OP_LWR = 8'hE6;
  localparam logic [ALUOP_W-1:0] OP_SB  = 8'hE8;
  localparam logic [ALUOP_W-1:0] OP_SH  = 8'hE9;
  localparam logic [ALUOP_W-1:0] OP_SWL = 8'hEA;
  localparam logic [ALUOP_W-1:0] OP_SW  = 8'hEB;
  localparam logic [ALUOP_W-1:0] OP_SWR = 8'hEE;
  localparam logic [ALUOP_W-1:0] OP_LL  = 8'hF0;
  localparam logic [ALUOP_W-1:0] OP_SC  = 8'hF8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } lsu_state_e;

  localparam logic [1:0] EXC_NONE     = 2'b00;
  localparam logic [1:0] EXC_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_TIMEOUT  = 2'b10;

  // Stores (SC included) are posted: they finish on grant without read data.
  function automatic logic f_is_store(input logic [ALUOP_W-1:0] op);
    case (op)
      OP_SB, OP_SH, OP_SW, OP_SWL, OP_SWR, OP_SC: f_is_store = 1'b1;
      default:                                    f_is_store = 1'b0;
    endcase
  endfunction

  // Misaligned naturally-aligned ops; always clear when the feature is off.
  function automatic logic f_misalign(input logic [ALUOP_W-1:0] op, input logic [1:0] lo);
`ifdef MEM_LSU_ALIGN_EXC_EN
    case (op)
      OP_LH, OP_LHU, OP_SH:        f_misalign = lo[0];
      OP_LW, OP_LL, OP_SW, OP_SC:  f_misalign = |lo;
      default:                     f_misalign = 1'b0;
    endcase
`else
    f_misalign = (op == op) & (lo == lo) & 1'b0;
`endif
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian byte-lane steering: store shift/strobes and load extract/extend/merge select.
module mem_lane_align
  import mem_lsu_pkg::*;
(
  input  logic [ALUOP_W-1:0] i_op,
  input  logic [1:0]         i_lo,
  input  logic [REG_W-1:0]   i_wdata,
  input  logic [REG_W-1:0]   i_rdata,
  output logic [REG_W-1:0]   o_st_data,
  output logic [3:0]         o_st_sel,
  output logic [REG_W-1:0]   o_ld_data,
  output logic [3:0]         o_ld_sel
);

  logic [4:0]       w_sh_hi;   // (3-b)*8
  logic [4:0]       w_sh_lo;   // b*8
  logic [4:0]       w_sh_hw;   // (1-addr[1])*16
  logic [REG_W-1:0] w_rd_byte;
  logic [REG_W-1:0] w_rd_half;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;

  assign w_sh_hi   = {~i_lo, 3'b000};
  assign w_sh_lo   = {i_lo, 3'b000};
  assign w_sh_hw   = {~i_lo[1], 4'b0000};
  assign w_rd_byte = i_rdata >> w_sh_hi;
  assign w_rd_half = i_rdata >> w_sh_hw;
  assign w_byte    = w_rd_byte[7:0];
  assign w_half    = w_rd_half[15:0];

  // Store data placement and byte strobes.
  always_comb begin
    o_st_data = '0;
    o_st_sel  = 4'b0000;
    case (i_op)
      OP_SB: begin
        o_st_data = i_wdata << w_sh_hi;
        o_st_sel  = 4'b0001 << (~i_lo);
      end
      OP_SH: begin
        o_st_data = i_wdata << w_sh_hw;
        o_st_sel  = i_lo[1] ? 4'b0011 : 4'b1100;
      end
      OP_SW, OP_SC: begin
        o_st_data = i_wdata;
        o_st_sel  = 4'b1111;
      end
      OP_SWL: begin
        o_st_data = i_wdata >> w_sh_lo;
        o_st_sel  = {i_lo < 2'd1, i_lo < 2'd2, i_lo < 2'd3, 1'b1};
      end
      OP_SWR: begin
        o_st_data = i_wdata << w_sh_hi;
        o_st_sel  = {1'b1, i_lo > 2'd0, i_lo > 2'd1, i_lo > 2'd2};
      end
      default: begin
        o_st_data = '0;
        o_st_sel  = 4'b0000;
      end
    endcase
  end

  // Load extraction, extension and rt merge enables.
  always_comb begin
    o_ld_data = '0;
    o_ld_sel  = 4'b1111;
    case (i_op)
      OP_LB:        o_ld_data = {{24{w_byte[7]}}, w_byte};
      OP_LBU:       o_ld_data = {24'h000000, w_byte};
      OP_LH:        o_ld_data = {{16{w_half[15]}}, w_half};
      OP_LHU:       o_ld_data = {16'h0000, w_half};
      OP_LW, OP_LL: o_ld_data = i_rdata;
      OP_LWL: begin
        o_ld_data = i_rdata << w_sh_lo;
        o_ld_sel  = {1'b1, i_lo < 2'd3, i_lo < 2'd2, i_lo < 2'd1};
      end
      OP_LWR: begin
        o_ld_data = i_rdata >> w_sh_hi;
        o_ld_sel  = {i_lo > 2'd2, i_lo > 2'd1, i_lo > 2'd0, 1'b1};
      end
      default: begin
        o_ld_data = '0;
        o_ld_sel  = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Handshaked load/store unit: EX valid/ready in, req/gnt/rvalid RAM port, WB valid/ready out.
// Owns the LLbit. Optional feature macro: MEM_LSU_ALIGN_EXC_EN.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int AW    = 32,
  parameter int TAG_W = 5,
  parameter int TMO_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ex_valid,
  output logic               ex_ready,
  input  logic [ALUOP_W-1:0] ex_aluop,
  input  logic [AW-1:0]      ex_addr,
  input  logic [REG_W-1:0]   ex_wdata,
  input  logic [TAG_W-1:0]   ex_tag,
  output logic               wb_valid,
  input  logic               wb_ready,
  output logic [REG_W-1:0]   wb_data,
  output logic [3:0]         wb_sel,
  output logic [TAG_W-1:0]   wb_tag,
  output logic [1:0]         wb_exc,
  output logic               mem_req,
  input  logic               mem_gnt,
  output logic               mem_we,
  output logic [AW-1:0]      mem_addr,
  output logic [3:0]         mem_sel,
  output logic [REG_W-1:0]   mem_wdata,
  input  logic               mem_rvalid,
  input  logic [REG_W-1:0]   mem_rdata,
  input  logic               ll_clr,
  output logic               llbit_o,
  output logic               busy
);

  lsu_state_e         r_state, w_next;
  logic [ALUOP_W-1:0] r_op;
  logic [AW-1:0]      r_addr;
  logic [REG_W-1:0]   r_wdata;
  logic [TAG_W-1:0]   r_tag;
  logic [TMO_W-1:0]   r_cnt;
  logic               r_llbit;
  logic [AW-3:0]      r_ll_word;
  logic [REG_W-1:0]   r_wb_data;
  logic [3:0]         r_wb_sel;
  logic [1:0]         r_wb_exc;

  logic               w_accept, w_ex_mis, w_ex_sc_fail, w_is_store, w_tmo;
  logic               w_st_gnt, w_ll_set, w_ll_kill;
  logic [REG_W-1:0]   w_st_data, w_ld_data;
  logic [3:0]         w_st_sel, w_ld_sel;

  mem_lane_align u_align (
    .i_op      (r_op),
    .i_lo      (r_addr[1:0]),
    .i_wdata   (r_wdata),
    .i_rdata   (mem_rdata),
    .o_st_data (w_st_data),
    .o_st_sel  (w_st_sel),
    .o_ld_data (w_ld_data),
    .o_ld_sel  (w_ld_sel)
  );

  assign w_accept     = ex_valid & ex_ready;
  assign w_ex_mis     = f_misalign(ex_aluop, ex_addr[1:0]);
  assign w_ex_sc_fail = (ex_aluop == OP_SC) & ~r_llbit;
  assign w_is_store   = f_is_store(r_op);
  assign w_tmo        = &r_cnt;
  assign w_st_gnt     = (r_state == ST_ISSUE) & mem_gnt & w_is_store;
  assign w_ll_set     = (r_state == ST_WAIT) & mem_rvalid & (r_op == OP_LL);
  assign w_ll_kill    = ll_clr | (w_st_gnt & ((r_op == OP_SC) | (r_addr[AW-1:2] == r_ll_word)));

  assign ex_ready  = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign wb_valid  = (r_state == ST_RESP);
  assign wb_data   = r_wb_data;
  assign wb_sel    = r_wb_sel;
  assign wb_exc    = r_wb_exc;
  assign wb_tag    = r_tag;
  assign mem_req   = (r_state == ST_ISSUE);
  assign mem_we    = mem_req & w_is_store;
  assign mem_addr  = {r_addr[AW-1:2], 2'b00};
  assign mem_sel   = mem_req ? w_st_sel : 4'b0000;
  assign mem_wdata = mem_req ? w_st_data : '0;
  assign llbit_o   = r_llbit;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state selection.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next = (w_ex_sc_fail || w_ex_mis) ? ST_RESP : ST_ISSUE;
        else          w_next = ST_IDLE;
      end
      ST_ISSUE: begin
        if (mem_gnt) w_next = w_is_store ? ST_RESP : ST_WAIT;
        else         w_next = ST_ISSUE;
      end
      ST_WAIT: begin
        if (mem_rvalid || w_tmo) w_next = ST_RESP;
        else                     w_next = ST_WAIT;
      end
      ST_RESP: begin
        if (wb_ready) w_next = ST_IDLE;
        else          w_next = ST_RESP;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Request latch, timeout counter and WB result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op      <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_tag     <= '0;
      r_cnt     <= '0;
      r_wb_data <= '0;
      r_wb_sel  <= 4'b0000;
      r_wb_exc  <= EXC_NONE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op    <= ex_aluop;
            r_addr  <= ex_addr;
            r_wdata <= ex_wdata;
            r_tag   <= ex_tag;
            r_cnt   <= '0;
            if (w_ex_mis) begin
              r_wb_data <= '0;
              r_wb_sel  <= 4'b0000;
              r_wb_exc  <= EXC_MISALIGN;
            end else if (w_ex_sc_fail) begin
              r_wb_data <= '0;
              r_wb_sel  <= 4'b1111;
              r_wb_exc  <= EXC_NONE;
            end
          end
        end
        ST_ISSUE: begin
          if (w_st_gnt) begin
            r_wb_data <= (r_op == OP_SC) ? 32'd1 : 32'd0;
            r_wb_sel  <= (r_op == OP_SC) ? 4'b1111 : 4'b0000;
            r_wb_exc  <= EXC_NONE;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            r_wb_data <= w_ld_data;
            r_wb_sel  <= w_ld_sel;
            r_wb_exc  <= EXC_NONE;
          end else if (w_tmo) begin
            r_wb_data <= '0;
            r_wb_sel  <= 4'b0000;
            r_wb_exc  <= EXC_TIMEOUT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // LLbit and the word it guards; clears win over a same-cycle set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_llbit   <= 1'b0;
      r_ll_word <= '0;
    end else begin
      if (w_ll_kill)     r_llbit <= 1'b0;
      else if (w_ll_set) r_llbit <= 1'b1;
      if (w_ll_set) r_ll_word <= r_addr[AW-1:2];
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu with a small scripted RAM responder.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               ex_valid = 1'b0, ex_ready;
  logic [ALUOP_W-1:0] ex_aluop = '0;
  logic [31:0]        ex_addr = '0, ex_wdata = '0;
  logic [4:0]         ex_tag = '0;
  logic               wb_valid, wb_ready = 1'b0;
  logic [31:0]        wb_data;
  logic [3:0]         wb_sel;
  logic [4:0]         wb_tag;
  logic [1:0]         wb_exc;
  logic               mem_req, mem_gnt = 1'b0, mem_we;
  logic [31:0]        mem_addr, mem_wdata;
  logic [3:0]         mem_sel;
  logic               mem_rvalid = 1'b0;
  logic [31:0]        mem_rdata = '0;
  logic               ll_clr = 1'b0, llbit_o, busy;

  mem_lsu #(.AW(32), .TAG_W(5), .TMO_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_aluop(ex_aluop), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_tag(ex_tag),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_sel(wb_sel),
    .wb_tag(wb_tag), .wb_exc(wb_exc), .mem_req(mem_req), .mem_gnt(mem_gnt),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_sel(mem_sel), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .ll_clr(ll_clr),
    .llbit_o(llbit_o), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  sel;
    logic [4:0]  tag;
    logic [1:0]  exc;
  } wb_t;

  typedef struct packed {
    wb_t w;
    logic chk_d;   // wb_data is only meaningful for loads and SC
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  // Observations from the last transaction.
  wb_t         o_wb;
  logic        o_saw_req, o_we, o_unstable;
  logic [31:0] o_maddr, o_mwdata;
  logic [3:0]  o_msel;
  int          o_lat;

  task automatic run_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] tag, input int gnt_dly, input int rv_dly,
                        input logic [31:0] rdata, input bit give_rv, input int hold);
    int k;
    o_saw_req = 1'b0; o_we = 1'b0; o_maddr = '0; o_msel = 4'b0000; o_mwdata = '0;
    o_unstable = 1'b0; o_lat = -1;
    ex_valid = 1'b1; ex_aluop = op; ex_addr = addr; ex_wdata = wdata; ex_tag = tag;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    if (mem_req === 1'b1) begin
      o_saw_req = 1'b1; o_we = mem_we; o_maddr = mem_addr; o_msel = mem_sel; o_mwdata = mem_wdata;
      for (int i = 0; i < gnt_dly; i++) begin
        @(posedge clk); #1;
        if (mem_req !== 1'b1 || mem_addr !== o_maddr || mem_sel !== o_msel ||
            mem_wdata !== o_mwdata || mem_we !== o_we) o_unstable = 1'b1;
      end
      mem_gnt = 1'b1;
      @(posedge clk); #1;
      mem_gnt = 1'b0;
      if (!o_we && give_rv) begin
        for (int i = 0; i < rv_dly; i++) begin @(posedge clk); #1; end
        mem_rvalid = 1'b1; mem_rdata = rdata;
        @(posedge clk); #1;
        mem_rvalid = 1'b0; mem_rdata = '0;
      end
    end
    k = 0;
    while (wb_valid !== 1'b1 && k < 400) begin
      if (mem_req === 1'b1) o_saw_req = 1'b1;
      @(posedge clk); #1;
      k++;
    end
    if (wb_valid !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL wb_valid_wait got 0 required 1 within 400 cycles");
    end
    o_lat = k;
    o_wb = {wb_data, wb_sel, wb_tag, wb_exc};
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (wb_valid !== 1'b1 || ex_ready !== 1'b0 || {wb_data, wb_sel, wb_tag, wb_exc} !== o_wb)
        o_unstable = 1'b1;
    end
    wb_ready = 1'b1;
    @(posedge clk); #1;
    wb_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({ex_ready, wb_valid, mem_req, mem_we, busy, llbit_o, wb_sel, wb_exc, mem_sel} !== {1'b1, 5'b00000, 4'h0, 2'b00, 4'h0}) begin
      n_err++;
      $display("FAIL reset_ctrl got %b required %b", {ex_ready, wb_valid, mem_req, mem_we, busy, llbit_o, wb_sel, wb_exc, mem_sel}, {1'b1, 15'b0});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({wb_data, mem_wdata, mem_addr, wb_tag} !== 101'd0 || ex_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_data got %h/%h/%h/%h rdy %b required zeros rdy 1", wb_data, mem_wdata, mem_addr, wb_tag, ex_ready);
    end
  endtask

  task automatic test_stores();
    exp_t e; wb_t got;
    logic [31:0] rt, ew;
    logic [3:0]  es;
    // SB from the example: two-cycle grant delay, posted write response.
    sb_q.push_back('{w: '{data: 32'h0, sel: 4'b0000, tag: 5'd3, exc: EXC_NONE}, chk_d: 1'b0});
    run_op(OP_SB, 32'h101, 32'h000000A5, 5'd3, 2, 0, 32'h0, 1'b1, 0);
    e = sb_q.pop_front(); got = o_wb; if (!e.chk_d) got.data = e.w.data;
    n_cmp++; if (got !== e.w) begin n_err++; $display("FAIL sb_wb got %h required %h", got, e.w); end
    n_cmp++;
    if ({o_saw_req, o_we, o_maddr, o_msel, o_mwdata, o_unstable} !== {1'b1, 1'b1, 32'h100, 4'b0100, 32'h00A50000, 1'b0}) begin
      n_err++; $display("FAIL sb_bus got req%b we%b %h %b %h unst%b required 1 1 00000100 0100 00a50000 0", o_saw_req, o_we, o_maddr, o_msel, o_mwdata, o_unstable);
    end
    n_cmp++; if (o_lat !== 0) begin n_err++; $display("FAIL sb_latency got %0d required 0", o_lat); end
    // SB across every byte offset against the lane model.
    rt = 32'h11223344;
    for (int b = 0; b < 4; b++) begin
      es = 4'b1000 >> b;
      ew = rt << ((3 - b) * 8);
      run_op(OP_SB, 32'h400 + b, rt, 5'd4, 0, 0, 32'h0, 1'b1, 0);
      n_cmp++;
      if ({o_msel, o_mwdata, o_maddr} !== {es, ew, 32'h400}) begin
        n_err++; $display("FAIL sb_lane%0d got %b %h %h required %b %h 00000400", b, o_msel, o_mwdata, o_maddr, es, ew);
      end
    end
    // SH, SWL, SWR at offsets 2 and 1.
    run_op(OP_SH, 32'h502, 32'hAABBCCDD, 5'd5, 1, 0, 32'h0, 1'b1, 0);
    n_cmp++; if ({o_msel, o_mwdata} !== {4'b0011, 32'hAABBCCDD}) begin n_err++; $display("FAIL sh_lane got %b %h required 0011 aabbccdd", o_msel, o_mwdata); end
    run_op(OP_SWL, 32'h501, 32'hAABBCCDD, 5'd5, 0, 0, 32'h0, 1'b1, 0);
    n_cmp++; if ({o_msel, o_mwdata} !== {4'b0111, 32'h00AABBCC}) begin n_err++; $display("FAIL swl_lane got %b %h required 0111 00aabbcc", o_msel, o_mwdata); end
    run_op(OP_SWR, 32'h501, 32'hAABBCCDD, 5'd5, 0, 0, 32'h0, 1'b1, 0);
    n_cmp++; if ({o_msel, o_mwdata} !== {4'b1100, 32'hCCDD0000}) begin n_err++; $display("FAIL swr_lane got %b %h required 1100 ccdd0000", o_msel, o_mwdata); end
  endtask

  task automatic test_loads();
    typedef struct packed { logic [7:0] op; logic [31:0] addr; logic [31:0] rd; logic [31:0] d; logic [3:0] s; } ld_t;
    ld_t tbl [7];
    exp_t e; wb_t got;
    tbl[0] = '{OP_LB,  32'h102, 32'h1122F344, 32'hFFFFFFF3, 4'b1111};
    tbl[1] = '{OP_LBU, 32'h102, 32'h1122F344, 32'h000000F3, 4'b1111};
    tbl[2] = '{OP_LH,  32'h100, 32'h80011234, 32'hFFFF8001, 4'b1111};
    tbl[3] = '{OP_LHU, 32'h102, 32'h80019234, 32'h00009234, 4'b1111};
    tbl[4] = '{OP_LW,  32'h104, 32'hCAFEF00D, 32'hCAFEF00D, 4'b1111};
    tbl[5] = '{OP_LWL, 32'h001, 32'hAABBCCDD, 32'hBBCCDD00, 4'b1110};
    tbl[6] = '{OP_LWR, 32'h001, 32'hAABBCCDD, 32'h0000AABB, 4'b0011};
    for (int i = 0; i < 7; i++) begin
      sb_q.push_back('{w: '{data: tbl[i].d, sel: tbl[i].s, tag: 5'(i + 8), exc: EXC_NONE}, chk_d: 1'b1});
      run_op(tbl[i].op, tbl[i].addr, 32'h0, 5'(i + 8), i % 2, 3, tbl[i].rd, 1'b1, 0);
      e = sb_q.pop_front(); got = o_wb;
      n_cmp++; if (got !== e.w) begin n_err++; $display("FAIL load%0d_wb got %h required %h", i, got, e.w); end
      n_cmp++;
      if ({o_saw_req, o_we, o_maddr} !== {1'b1, 1'b0, tbl[i].addr & 32'hFFFFFFFC}) begin
        n_err++; $display("FAIL load%0d_bus got req%b we%b %h", i, o_saw_req, o_we, o_maddr);
      end
    end
    // Minimum latency: grant and rvalid on the earliest cycles, wb_valid right after rvalid.
    run_op(OP_LW, 32'h108, 32'h0, 5'd1, 0, 0, 32'h12345678, 1'b1, 0);
    n_cmp++; if ({o_lat, o_wb.data} !== {32'd0, 32'h12345678}) begin n_err++; $display("FAIL min_latency got %0d %h required 0 12345678", o_lat, o_wb.data); end
  endtask

  task automatic test_llsc();
    exp_t e; wb_t got;
    run_op(OP_LL, 32'h200, 32'h0, 5'd2, 0, 1, 32'hDEADBEEF, 1'b1, 0);
    n_cmp++; if ({llbit_o, o_wb.data, o_wb.sel} !== {1'b1, 32'hDEADBEEF, 4'b1111}) begin n_err++; $display("FAIL ll_set got %b %h %b required 1 deadbeef 1111", llbit_o, o_wb.data, o_wb.sel); end
    sb_q.push_back('{w: '{data: 32'd1, sel: 4'b1111, tag: 5'd6, exc: EXC_NONE}, chk_d: 1'b1});
    run_op(OP_SC, 32'h200, 32'h00000055, 5'd6, 1, 0, 32'h0, 1'b1, 0);
    e = sb_q.pop_front(); got = o_wb;
    n_cmp++; if (got !== e.w) begin n_err++; $display("FAIL sc_ok_wb got %h required %h", got, e.w); end
    n_cmp++;
    if ({o_saw_req, o_we, o_msel, o_mwdata, llbit_o} !== {1'b1, 1'b1, 4'b1111, 32'h55, 1'b0}) begin
      n_err++; $display("FAIL sc_ok_bus got req%b we%b %b %h ll%b required 1 1 1111 00000055 0", o_saw_req, o_we, o_msel, o_mwdata, llbit_o);
    end
    sb_q.push_back('{w: '{data: 32'd0, sel: 4'b1111, tag: 5'd7, exc: EXC_NONE}, chk_d: 1'b1});
    run_op(OP_SC, 32'h200, 32'h00000066, 5'd7, 0, 0, 32'h0, 1'b1, 0);
    e = sb_q.pop_front(); got = o_wb;
    n_cmp++; if ({got, o_saw_req} !== {e.w, 1'b0}) begin n_err++; $display("FAIL sc_fail got %h req%b required %h req0", got, o_saw_req, e.w); end
    // ll_clr between LL and SC.
    run_op(OP_LL, 32'h200, 32'h0, 5'd2, 0, 0, 32'h1, 1'b1, 0);
    ll_clr = 1'b1; @(posedge clk); #1; ll_clr = 1'b0;
    run_op(OP_SC, 32'h200, 32'h77, 5'd9, 0, 0, 32'h0, 1'b1, 0);
    n_cmp++; if ({o_wb.data, o_saw_req} !== {32'd0, 1'b0}) begin n_err++; $display("FAIL sc_after_clr got %h req%b required 0 req0", o_wb.data, o_saw_req); end
    // Store to the guarded word clears LLbit; a store elsewhere leaves it.
    run_op(OP_LL, 32'h300, 32'h0, 5'd2, 0, 0, 32'h1, 1'b1, 0);
    run_op(OP_SW, 32'h304, 32'h1, 5'd2, 0, 0, 32'h0, 1'b1, 0);
    n_cmp++; if (llbit_o !== 1'b1) begin n_err++; $display("FAIL ll_other_word got %b required 1", llbit_o); end
    run_op(OP_SB, 32'h301, 32'h1, 5'd2, 0, 0, 32'h0, 1'b1, 0);
    n_cmp++; if (llbit_o !== 1'b0) begin n_err++; $display("FAIL ll_same_word got %b required 0", llbit_o); end
  endtask

  task automatic test_timeout();
    exp_t e; wb_t got;
    sb_q.push_back('{w: '{data: 32'h0, sel: 4'b0000, tag: 5'd11, exc: EXC_TIMEOUT}, chk_d: 1'b0});
    run_op(OP_LW, 32'h040, 32'h0, 5'd11, 0, 0, 32'h0, 1'b0, 5);
    e = sb_q.pop_front(); got = o_wb; if (!e.chk_d) got.data = e.w.data;
    n_cmp++; if (got !== e.w) begin n_err++; $display("FAIL timeout_wb got %h required %h", got, e.w); end
    n_cmp++; if (o_lat < 255 || o_lat > 256) begin n_err++; $display("FAIL timeout_cycles got %0d required 255..256", o_lat); end
    n_cmp++; if (o_unstable !== 1'b0) begin n_err++; $display("FAIL resp_hold_stable got unstable=%b required 0", o_unstable); end
  endtask

  task automatic test_align();
    exp_t e; wb_t got;
`ifdef MEM_LSU_ALIGN_EXC_EN
    sb_q.push_back('{w: '{data: 32'h0, sel: 4'b0000, tag: 5'd12, exc: EXC_MISALIGN}, chk_d: 1'b0});
    run_op(OP_LW, 32'h102, 32'h0, 5'd12, 0, 0, 32'h01020304, 1'b1, 0);
    e = sb_q.pop_front(); got = o_wb; if (!e.chk_d) got.data = e.w.data;
    n_cmp++; if ({got, o_saw_req} !== {e.w, 1'b0}) begin n_err++; $display("FAIL align_exc got %h req%b required %h req0", got, o_saw_req, e.w); end
`else
    sb_q.push_back('{w: '{data: 32'h01020304, sel: 4'b1111, tag: 5'd12, exc: EXC_NONE}, chk_d: 1'b1});
    run_op(OP_LW, 32'h102, 32'h0, 5'd12, 0, 0, 32'h01020304, 1'b1, 0);
    e = sb_q.pop_front(); got = o_wb;
    n_cmp++; if ({got, o_maddr} !== {e.w, 32'h100}) begin n_err++; $display("FAIL align_ignore got %h %h required %h 00000100", got, o_maddr, e.w); end
`endif
  endtask

  task automatic test_reset_mid();
    run_op(OP_LL, 32'h600, 32'h0, 5'd1, 0, 0, 32'h5, 1'b1, 0);
    ex_valid = 1'b1; ex_aluop = OP_LW; ex_addr = 32'h604; ex_tag = 5'd1;
    @(posedge clk); #1;
    ex_valid = 1'b0; mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, ex_ready, mem_req, wb_valid, llbit_o} !== {1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL reset_mid got busy%b rdy%b req%b v%b ll%b required 0 1 0 0 0", busy, ex_ready, mem_req, wb_valid, llbit_o);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_stores();
    test_loads();
    test_llsc();
    test_timeout();
    test_align();
    test_reset_mid();
    n_cmp++;
    if (sb_q.size() !== 0) begin n_err++; $display("FAIL scoreboard_drain got %0d entries required 0", sb_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
Handshaked load/store unit that replaces the fixed one-cycle memory stage. It accepts one memory op from EX per valid/ready transfer and drives a req/gnt/rvalid data-RAM port that tolerates any grant and response latency. It performs big-endian byte-lane alignment for LB/LBU/LH/LHU/LW/LWL/LWR/LL/SB/SH/SW/SWL/SWR/SC, owns the LLbit, and returns results to WB through valid/ready.

Parameters:
AW, 32, data address width; mem_addr is {ex_addr[AW-1:2],2'b00}
TAG_W, 5, destination-register tag width carried from EX to WB
TMO_W, 8, width of the response-timeout counter; timeout fires at 2^TMO_W-1 cycles in WAIT

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ex_valid  in  1  EX presents a memory op
ex_ready  out  1  LSU accepts; transfer = ex_valid & ex_ready
ex_aluop  in  `AluOpBusWidth  load/store op code (`EXE_*_OP)
ex_addr  in  AW  effective byte address
ex_wdata  in  `RegWidth  store data (rt)
ex_tag  in  TAG_W  destination register
wb_valid  out  1  result available
wb_ready  in  1  WB consumes result
wb_data  out  `RegWidth  aligned load data; SC status (1/0)
wb_sel  out  4  byte enables for the rt merge; 0 = no write
wb_tag  out  TAG_W  echoed tag
wb_exc  out  2  00 ok, 01 misaligned, 10 bus timeout
mem_req  out  1  RAM request; held until mem_gnt
mem_gnt  in  1  RAM accepts the request
mem_we  out  1  write request
mem_addr  out  AW  word address
mem_sel  out  4  byte-lane strobes
mem_wdata  out  `RegWidth  lane-aligned store data
mem_rvalid  in  1  read data valid (loads only)
mem_rdata  in  `RegWidth  read data
ll_clr  in  1  clears LLbit (ERET or exception)
llbit_o  out  1  current LLbit
busy  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE, LLbit=0. All outputs are 0 except ex_ready=1.
- FSM states and transitions:
  - IDLE: ex_ready=1. On transfer, latch aluop, addr, wdata and tag.
    - Go to RESP if the op is SC with LLbit=0, or if the op is flagged misaligned.
    - Otherwise go to ISSUE.
  - ISSUE: mem_req=1, with addr/we/sel/wdata stable from latched values.
    - On mem_gnt, a store goes to RESP (posted write). A load goes to WAIT.
  - WAIT: increment the timeout counter each cycle.
    - On mem_rvalid, capture the aligned result and go to RESP.
    - When the counter reaches all-ones, set exc=10, wb_sel=0 and go to RESP.
    - If mem_rvalid and the timeout coincide, mem_rvalid wins.
  - RESP: wb_valid=1, with all wb_* outputs stable. On wb_ready go to IDLE.
- ex_ready is 1 only in IDLE. Minimum latency is 3 cycles: accept, then grant on the next cycle, then rvalid on the next cycle; wb_valid asserts 1 cycle after rvalid.
- Store data and strobes, with byte offset b=addr[1:0] and big-endian lane mapping (b=0 is bits 31:24):
  - SB: data = rt << (3-b)*8; sel = one-hot bit (3-b).
  - SH: data = rt << (1-addr[1])*16; sel = 1100 if addr[1]=0, else 0011.
  - SW/SC: data = rt; sel = 1111.
  - SWL: data = rt >> b*8; sel bits 3..0 = (b<1, b<2, b<3, 1).
  - SWR: data = rt << (3-b)*8; sel = (1, b>0, b>1, b>2).
- Load result:
  - LB/LBU: byte = rdata >> (3-b)*8, sign- or zero-extended; wb_sel=1111.
  - LH/LHU: same, using halfword addr[1]; wb_sel=1111.
  - LW/LL: data = rdata; wb_sel=1111.
  - LWL: data = rdata << b*8; wb_sel = (1, b<3, b<2, b<1).
  - LWR: data = rdata >> (3-b)*8; wb_sel = (b>2, b>1, b>0, 1).
- Stores return wb_valid with wb_sel=0000. SC returns wb_data=1 on success and 0 on failure, with wb_sel=1111.
- LLbit:
  - Set when LL completes on mem_rvalid.
  - Cleared by a successful SC grant, by ll_clr, and by any store granted to the same word address as the LL.
  - ll_clr has priority over a same-cycle set.
- Reset mid-transaction returns to IDLE immediately. The RAM must tolerate an abandoned req.

Optional Feature:
MEM_LSU_ALIGN_EXC_EN
- Defined: LH/LHU/SH with addr[0]=1, or LW/LL/SW/SC with addr[1:0]!=0, skip the bus and go IDLE->RESP. The response is wb_exc=01, wb_sel=0, and LLbit is unchanged.
- Undefined: low address bits are ignored (halfword uses addr[1]; word uses b=0), and wb_exc is never 01.

Decomposition:
- defines.v gains: `MEM_LSU_IDLE/ISSUE/WAIT/RESP (2-bit), `MEM_EXC_NONE/MISALIGN/TIMEOUT (2-bit).
- Registers use gnrl_dfflr.
- One combinational sub-module, mem_lane_align, contains the store shift/strobe logic and the load extract/extend/merge-select logic, so it can be unit-tested alone.

Test Plan:
- SB rt=0x000000A5, addr=0x101, gnt after 2 cycles -> mem_addr=0x100, mem_sel=0100, mem_wdata=0x00A50000; wb_sel=0000, wb_valid 1 cycle after gnt.
- LB addr=0x102, rdata=0x1122F344, rvalid 3 cycles after gnt -> wb_data=0xFFFFFFF3, wb_sel=1111; LBU gives 0x000000F3.
- LWL addr=0x001, rdata=0xAABBCCDD -> wb_data=0xBBCCDD00, wb_sel=1110. LWR addr=0x001, same rdata -> wb_data=0x0000AABB, wb_sel=0011.
- LL 0x200, then SC 0x200 -> SC writes with sel=1111 and returns wb_data=1. A second SC -> no mem_req, wb_data=0. LL, then ll_clr, then SC -> wb_data=0.
- Load granted but no rvalid for 255 cycles (TMO_W=8) -> wb_exc=10, wb_sel=0000. Hold wb_ready=0 for 5 cycles -> outputs stable and ex_ready=0 throughout.
- With MEM_LSU_ALIGN_EXC_EN: LW addr=0x102 -> mem_req never asserts, wb_exc=01. Without it -> read of 0x100 with wb_exc=00.
